// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants
// Purpose: arbiter state encoding, data width and full byte-enable constant.
// Ports: none (package).
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [3:0] BE_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        IDROP = 2'd2,
        DBUSY = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch and data stages
// Purpose: grants one outstanding transaction at a time, data side first with a
//          starvation limit for fetch; flushes cancel an in-flight fetch result.
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr/if_flush       fetch request, PC, branch-taken cancel
//   if_valid/if_rdata             fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata/d_be data access request and attributes
//   d_valid/d_rdata               data completion pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  registered bus request
//   mem_ack/mem_rdata             bus completion and read data
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_valid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_t state, state_next;
    logic [2:0] starve_cnt;
    logic       grant_d;
    logic       grant_i;
    logic       i_done;
    logic       d_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch is waiting and has already been passed over too often.
                if (d_req && (!if_req || (32'(starve_cnt) < STARVE_LIMIT))) begin
                    grant_d    = 1'b1;
                    state_next = DBUSY;
                end else if (if_req && !if_flush) begin
                    grant_i    = 1'b1;
                    state_next = IBUSY;
                end
            end
            IBUSY: begin
                if (mem_ack) begin
                    // A flush on the ack edge makes the returning word stale.
                    i_done     = !if_flush;
                    state_next = IDLE;
                end else if (if_flush) begin
                    state_next = IDROP;
                end
            end
            IDROP: begin
                if (mem_ack) begin
                    state_next = IDLE;
                end
            end
            DBUSY: begin
                if (mem_ack) begin
                    d_done     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'h0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            starve_cnt <= 3'd0;
        end else begin
            if_valid <= i_done;
            d_valid  <= d_done;

            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
                if (!if_req) begin
                    starve_cnt <= 3'd0;
                end else if (starve_cnt != 3'd7) begin
                    starve_cnt <= starve_cnt + 3'd1;
                end
            end else if (grant_i) begin
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_be     <= BE_FULL;
                starve_cnt <= 3'd0;
            end else if (state != IDLE && mem_ack) begin
                // Attributes are left as they were; only the request drops.
                mem_req <= 1'b0;
            end

            if (i_done) begin
                if_rdata <= mem_rdata;
            end
            if (d_done && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule
